// File: rtl/keccak_pkg.sv
// Definitions shared by the Keccak sequencer and the requester arbiter:
// FSM state encoding, job geometry and counter sizing.
package keccak_pkg;

    localparam int KECCAK_W_IN   = 24;
    localparam int KECCAK_W_OUT  = 24;
    localparam int KECCAK_BEAT_W = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;

    // Width that can hold 0 .. max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/keccak_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request found at
// ptr+1, ptr+2, ... (wrapping) wins.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0]   cand [NREQ];
    logic [NREQ-1:0] hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = IW'((32'(ptr) + 32'(gi) + 32'd1) % 32'(NREQ));
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        idx = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
        any    = |req;
        onehot = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/keccak_share_arbiter.sv
// Shares one Keccak core among NREQ requesters: grants one owner per job,
// forwards its input beats to the core and routes output beats back.
module keccak_share_arbiter
    import keccak_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W_IN    = KECCAK_W_IN,
    parameter int W_OUT   = KECCAK_W_OUT,
    parameter int TIMEOUT = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               req_we,
    input  logic [KECCAK_BEAT_W*NREQ-1:0] req_din,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [KECCAK_BEAT_W-1:0]      rsp_dout,
    output logic [NREQ-1:0]               done,
    output logic [NREQ-1:0]               err,
    output logic                          keccak_we,
    output logic [KECCAK_BEAT_W-1:0]      keccak_din,
    input  logic                          keccak_valid,
    input  logic [KECCAK_BEAT_W-1:0]      keccak_dout,
    output logic                          busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(W_IN, W_OUT, TIMEOUT);

    localparam logic [CW-1:0] IN_LAST  = CW'(W_IN - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(W_OUT - 1);
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic [NREQ-1:0] err_reg, err_next;
    logic [CW-1:0]   beat_reg, beat_next;
    logic [CW-1:0]   wd_reg, wd_next;
    logic            drop_reg, drop_next;

    logic [KECCAK_BEAT_W-1:0] din_arr [NREQ];
    logic [KECCAK_BEAT_W-1:0] owner_din;
    logic                     owner_req;
    logic                     owner_we;
    logic                     in_job;
    logic                     suppress;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
        assign din_arr[gi] = req_din[gi*KECCAK_BEAT_W +: KECCAK_BEAT_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_req = req[owner_reg];
    assign owner_we  = req_we[owner_reg];
    assign owner_din = din_arr[owner_reg];
    assign in_job    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    // An owner that walks away mid-job stays silenced even if it re-raises req.
    assign suppress  = drop_reg || !owner_req;

    assign gnt        = gnt_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign keccak_we  = (state_reg == ST_LOAD) && owner_we;
    assign keccak_din = (state_reg == ST_LOAD) ? owner_din : '0;
    assign rsp_valid  = (in_job && keccak_valid && !suppress) ? gnt_reg : '0;
    assign rsp_dout   = in_job ? keccak_dout : '0;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        err_next   = '0;
        beat_next  = beat_reg;
        wd_next    = wd_reg;
        drop_next  = drop_reg;

        case (state_reg)
            ST_IDLE: begin
                gnt_next  = '0;
                drop_next = 1'b0;
                if (pick_any) begin
                    state_next = ST_LOAD;
                    owner_next = pick_idx;
                    ptr_next   = pick_idx;
                    gnt_next   = pick_onehot;
                end
            end
            ST_LOAD: begin
                if (!owner_req) begin
                    state_next = ST_RELEASE;
                    gnt_next   = '0;
                end else if (owner_we) begin
                    if (beat_reg == IN_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                drop_next = suppress;
                if (keccak_valid) begin
                    if (W_OUT == 1) begin
                        state_next = ST_RELEASE;
                        gnt_next   = '0;
                        done_next  = suppress ? '0 : gnt_reg;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (wd_reg == WD_LAST) begin
                    state_next = ST_RELEASE;
                    gnt_next   = '0;
                    err_next   = gnt_reg;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                drop_next = suppress;
                if (keccak_valid) begin
                    if (beat_reg == OUT_LAST) begin
                        state_next = ST_RELEASE;
                        gnt_next   = '0;
                        done_next  = suppress ? '0 : gnt_reg;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        // Counters restart on every state change; the beat that ends RUN is
        // already the first output beat, so DRAIN starts counting at one.
        if (state_next != state_reg) begin
            beat_next = (state_next == ST_DRAIN) ? CW'(1) : '0;
            wd_next   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
            beat_reg  <= '0;
            wd_reg    <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            beat_reg  <= beat_next;
            wd_reg    <= wd_next;
            drop_reg  <= drop_next;
        end
    end

endmodule

// File: tb/tb_keccak_share_arbiter.sv
// Directed bench for keccak_share_arbiter: grant order, beat routing,
// timeout abort, owner drop and mid-job reset.
module tb_keccak_share_arbiter;

    localparam int NREQ  = 2;
    localparam int W_IN  = 24;
    localparam int W_OUT = 24;
    localparam int TO    = 16;

    logic                   CLK;
    logic                   RST;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [64*NREQ-1:0]     req_din;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [63:0]            rsp_dout;
    logic [NREQ-1:0]        done;
    logic [NREQ-1:0]        err;
    logic                   keccak_we;
    logic [63:0]            keccak_din;
    logic                   keccak_valid;
    logic [63:0]            keccak_dout;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    keccak_share_arbiter #(
        .NREQ    (NREQ),
        .W_IN    (W_IN),
        .W_OUT   (W_OUT),
        .TIMEOUT (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req          (req),
        .req_we       (req_we),
        .req_din      (req_din),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_dout     (rsp_dout),
        .done         (done),
        .err          (err),
        .keccak_we    (keccak_we),
        .keccak_din   (keccak_din),
        .keccak_valid (keccak_valid),
        .keccak_dout  (keccak_dout),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] din_pat(input int own, input int b);
        return {32'(own + 1) * 32'h1111_1111, 32'(b) * 32'h0101_0101};
    endfunction

    function automatic logic [63:0] rsp_pat(input int v);
        return 64'hC0DE_0000_0000_0000 + 64'(v);
    endfunction

    task automatic set_din(input int own, input int b);
        for (int i = 0; i < NREQ; i++) begin
            req_din[64*i +: 64] = (i == own) ? din_pat(own, b) : ~din_pat(own, b);
        end
    endtask

    // Starts in IDLE with req already visible: first tick grants, then nbeats
    // input beats; a non-owner strobe is inserted and must be ignored.
    task automatic load_phase(input int own, input int nbeats);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << own;
        tick;
        chk("grant", gnt, oh);
        chk("busy_load", busy, 1);
        for (int b = 0; b < nbeats; b++) begin
            if (b == 5) begin
                req_we = ~oh;
                set_din(own, 99);
                #1;
                chk("nonowner_we", keccak_we, 0);
                tick;
            end
            req_we = b[0] ? {NREQ{1'b1}} : oh;
            set_din(own, b);
            #1;
            chk("load_we", keccak_we, 1);
            chk("load_din", keccak_din, din_pat(own, b));
            chk("load_gnt", gnt, oh);
            tick;
        end
    endtask

    // Starts on the first RUN cycle; one idle RUN cycle, then W_OUT valids.
    // The owner drops req at output beat drop_at (W_OUT or more: never).
    task automatic drain_phase(input int own, input int drop_at);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << own;
        req_we = '0;
        keccak_valid = 1'b0;
        #1;
        chk("run_we", keccak_we, 0);
        chk("run_rsp", rsp_valid, 0);
        tick;
        for (int v = 0; v < W_OUT; v++) begin
            if (v == drop_at) req[own] = 1'b0;
            keccak_valid = 1'b1;
            keccak_dout = rsp_pat(v);
            #1;
            chk("rsp_valid", rsp_valid, (v < drop_at) ? oh : '0);
            if (v < drop_at) chk("rsp_dout", rsp_dout, rsp_pat(v));
            chk("done_early", done, 0);
            tick;
        end
        keccak_valid = 1'b0;
        #1;
        chk("done", done, (drop_at >= W_OUT) ? oh : '0);
        chk("release_gnt", gnt, 0);
        chk("release_busy", busy, 1);
        chk("release_err", err, 0);
        tick;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
    endtask

    initial begin
        RST = 1'b0;
        req = '0;
        req_we = '0;
        req_din = '0;
        keccak_valid = 1'b0;
        keccak_dout = '0;

        // Reset state
        tick;
        tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", keccak_we, 0);
        chk("rst_din", keccak_din, 0);
        chk("rst_rsp", rsp_valid, 0);
        RST = 1'b1;

        // 1: single requester, full job
        req = 2'b01;
        #1;
        chk("t1_gnt_latency", gnt, 0);
        load_phase(0, W_IN);
        drain_phase(0, W_OUT);
        req = '0;
        tick;
        chk("t1_idle", busy, 0);
        $display("test1 single job done");

        // 2: both requesting continuously, order 1,0,1,0 from ptr=0
        RST = 1'b0;
        tick;
        RST = 1'b1;
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            load_phase(j[0] ? 0 : 1, W_IN);
            drain_phase(j[0] ? 0 : 1, W_OUT);
            $display("test2 job %0d owner %0d", j, j[0] ? 0 : 1);
        end
        req = '0;
        tick;

        // 4: no keccak_valid -> timeout abort, then next requester served
        req = 2'b01;
        load_phase(0, W_IN);
        req_we = '0;
        for (int k = 1; k <= TO; k++) begin
            chk("t4_no_err", err, 0);
            chk("t4_gnt", gnt, 2'b01);
            tick;
        end
        chk("t4_err", err, 2'b01);
        chk("t4_done", done, 0);
        chk("t4_gnt_release", gnt, 0);
        chk("t4_busy", busy, 1);
        req = 2'b10;
        tick;
        chk("t4_err_pulse", err, 0);
        chk("t4_idle", busy, 0);
        load_phase(1, W_IN);
        drain_phase(1, W_OUT);
        req = '0;
        $display("test4 timeout abort done");

        // 5a: owner drops req at LOAD beat 10
        req = 2'b01;
        load_phase(0, 10);
        req = '0;
        req_we = '0;
        #1;
        chk("t5_we", keccak_we, 0);
        tick;
        chk("t5_gnt", gnt, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        chk("t5_busy_rel", busy, 1);
        tick;
        chk("t5_idle", busy, 0);
        chk("t5_done2", done, 0);

        // 5b: owner drops req during DRAIN
        req = 2'b01;
        load_phase(0, W_IN);
        drain_phase(0, 5);
        $display("test5 owner drop done");

        // 6: reset in the middle of DRAIN, then a fresh job
        req = 2'b01;
        load_phase(0, W_IN);
        req_we = '0;
        tick;
        for (int v = 0; v < 6; v++) begin
            keccak_valid = 1'b1;
            keccak_dout = rsp_pat(v);
            tick;
        end
        RST = 1'b0;
        tick;
        RST = 1'b1;
        #1;
        chk("t6_gnt", gnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rsp", rsp_valid, 0);
        chk("t6_dout", rsp_dout, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_we", keccak_we, 0);
        chk("t6_din", keccak_din, 0);
        keccak_valid = 1'b0;
        load_phase(0, W_IN);
        drain_phase(0, W_OUT);
        req = '0;
        tick;
        $display("test6 reset mid-drain done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
